countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Parameterizable N-bit down counter (timer) with a loadable reload value, start/stop control, and one-shot or periodic operation.
- Emits a one-cycle terminal-count pulse when the count expires.
- Serves as the decrementing counterpart of the team's free-running up counter. Used for timeouts, tick generation and delay sequencing.
- Count advances only on cycles where en=1, so an external prescaler can drive it.

Parameters:
- N, 8, counter and reload width in bits (N >= 2).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  count enable; one decrement per clk with en=1 while RUN.
- load_valid  input  1  load request; qualifies load_value.
- load_ready  output  1  high when a load can be accepted (state IDLE or EXPIRED).
- load_value  input  N  new reload value; transferred when load_valid & load_ready.
- start  input  1  single-cycle start/restart request.
- stop  input  1  single-cycle stop (pause) request.
- periodic  input  1  mode select, sampled only on an accepted start: 1=periodic, 0=one-shot.
- q  output  N  current count.
- busy  output  1  high in RUN.
- tc  output  1  terminal-count pulse; exactly one cycle per expiry.
- start_err  output  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (rst_n=0 at posedge), regardless of state:
  - q=0, reload=0, mode=one-shot, state=IDLE.
  - busy=0, tc=0, start_err=0; load_ready=1 on the next cycle.
- States are IDLE, RUN and EXPIRED. Outputs are registered; load_ready is decoded from state.
- Load: on a load_valid & load_ready cycle, reload<=load_value and q<=load_value. The state is unchanged (EXPIRED goes to IDLE). Loads are ignored in RUN (load_ready=0).
- IDLE + start:
  - Effective value is load_value if a load is accepted the same cycle, else q.
  - If the effective value != 0: RUN next cycle, busy=1, mode<=periodic.
  - If it == 0: stay IDLE, start_err=1 for one cycle.
- RUN, en=1:
  - If q>1: q<=q-1.
  - If q==1, one-shot: q<=0, tc=1 next cycle, state EXPIRED, busy=0.
  - If q==1, periodic: q<=reload, tc=1 next cycle, stay RUN.
  - Resulting period is reload en-cycles per tc.
- RUN, en=0: q holds.
- RUN + stop: IDLE next cycle, q holds (pause).
  - A later start resumes from q.
  - If stop coincides with the q==1 & en decrement: the decrement and tc still occur, then the state goes to IDLE (not RUN/EXPIRED).
- stop + start in the same cycle: stop wins; start is ignored with no start_err.
- start while RUN: ignored, no error.
- EXPIRED + start:
  - If reload != 0: q<=reload, RUN (retrigger).
  - Else start_err pulse.
- stop in IDLE or EXPIRED: no effect.
- Arithmetic is unsigned modulo 2^N; q never underflows (0 is never decremented).
- Latency:
  - start to busy=1: 1 cycle.
  - In RUN, q changes the cycle after each en=1 sample.
  - tc is high in the same cycle the new q (0 or reload) is visible.
- reload = 2^N-1 is legal and gives a period of 2^N-1 en-cycles.

Decomposition:
- Shared package countdown_timer_pkg holds:
  - State enum: IDLE, RUN, EXPIRED.
  - Mode constants: MODE_ONESHOT=0, MODE_PERIODIC=1.
- Single module; no sub-module needed. Datapath (q, reload) and FSM live in one file.

Test Plan:
- Reset/load/one-shot: N=8. Reset, then load 5 and start next cycle with en=1 continuously, periodic=0 → busy rises 1 cycle after start; q=5,4,3,2,1,0; tc high exactly once with q=0; state EXPIRED, busy=0, load_ready=1.
- Periodic with gated en: load 3, start with periodic=1, en toggling 1/0 → q decrements only on en=1 cycles; tc pulses every 3 en-cycles with q=3 on the tc cycle; 4 pulses over 12 en-cycles; busy stays 1.
- Stop/resume and collision: load 10, run 4 en-cycles (q=6), assert stop+start together → IDLE, q=6, no start_err. Start again → resumes to 0 after 6 en-cycles with a single tc.
- Rejects: start with q=0 after reset → start_err 1 cycle, stays IDLE. Load_valid with value 7 in RUN → load_ready=0 and q unaffected.
- Same-cycle load+start and retrigger: load 2 and start in the same cycle → RUN with q=2, expires after 2 en. Start in EXPIRED → q=2, RUN again.
- Reset mid-operation: assert rst_n=0 while RUN, q=0x80, periodic → next cycle q=0, busy=0, tc=0, reload=0. A subsequent start with no load gives start_err.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer: FSM state encoding
// and the one-shot/periodic mode values.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/countdown_timer.sv
// N-bit loadable down counter with start/stop control, one-shot or periodic
// reload, and a single-cycle terminal-count pulse on each expiry.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         tc,
  output logic         start_err
);

  state_t       state, state_n;
  logic [N-1:0] q_n;
  logic [N-1:0] reload, reload_n;
  logic         mode, mode_n;
  logic         busy_n, tc_n, start_err_n;
  logic         load_acc;
  logic         start_req;
  logic [N-1:0] eff_value;

  // Saturating decrement: zero is never wrapped to all-ones.
  function automatic logic [N-1:0] count_down(input logic [N-1:0] v);
    if (v == '0) begin
      return v;
    end
    return v - N'(1);
  endfunction

  assign load_ready = (state != RUN);
  assign load_acc   = load_valid & load_ready;
  // A simultaneous stop cancels the start silently.
  assign start_req  = start & ~stop;

  // Value a start would launch with: a same-cycle load takes priority, an
  // expired timer retriggers from its reload value, a paused one resumes.
  always_comb begin
    eff_value = q;
    if (load_acc) begin
      eff_value = load_value;
    end else if (state == EXPIRED) begin
      eff_value = reload;
    end
  end

  always_comb begin
    state_n     = state;
    q_n         = q;
    reload_n    = reload;
    mode_n      = mode;
    tc_n        = 1'b0;
    start_err_n = 1'b0;

    case (state)
      IDLE, EXPIRED: begin
        if (load_acc) begin
          reload_n = load_value;
          q_n      = load_value;
          state_n  = IDLE;
        end
        if (start_req) begin
          if (eff_value != '0) begin
            q_n     = eff_value;
            mode_n  = periodic;
            state_n = RUN;
          end else begin
            start_err_n = 1'b1;
          end
        end
      end

      RUN: begin
        if (en) begin
          if (q == N'(1)) begin
            tc_n = 1'b1;
            if (mode == MODE_PERIODIC) begin
              q_n = reload;
            end else begin
              q_n     = '0;
              state_n = EXPIRED;
            end
          end else begin
            q_n = count_down(q);
          end
        end
        // Pause overrides both staying in RUN and expiring; the final
        // decrement and tc above still take effect.
        if (stop) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy_n = (state_n == RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      reload    <= '0;
      mode      <= MODE_ONESHOT;
      busy      <= 1'b0;
      tc        <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      reload    <= reload_n;
      mode      <= mode_n;
      busy      <= busy_n;
      tc        <= tc_n;
      start_err <= start_err_n;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer: each stimulus cycle queues
// its expected outputs and a monitor compares them one cycle later.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [7:0] q;
  logic       busy;
  logic       tc;
  logic       start_err;

  typedef struct {
    logic [11:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic [11:0] act;
  int checks   = 0;
  int failures = 0;

  countdown_timer #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .periodic   (periodic),
    .q          (q),
    .busy       (busy),
    .tc         (tc),
    .start_err  (start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares the outputs produced by each posedge against the
  // expectation queued for that cycle. load_ready must be the inverse of busy.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      act = {q, busy, tc, start_err, load_ready};
      checks++;
      if (act !== cur.v) begin
        failures++;
        $display("FAIL %s: got q=%0d busy=%b tc=%b err=%b lr=%b, expected q=%0d busy=%b tc=%b err=%b lr=%b",
                 cur.nm, act[11:4], act[3], act[2], act[1], act[0],
                 cur.v[11:4], cur.v[3], cur.v[2], cur.v[1], cur.v[0]);
      end
    end
  end

  task automatic step(input bit rn, input bit en_i, input bit lv, input logic [7:0] lval,
                      input bit st, input bit sp, input bit per,
                      input logic [7:0] eq, input bit eb, input bit et, input bit ee,
                      input string nm);
    exp_t e;
    @(negedge clk);
    rst_n      = rn;
    en         = en_i;
    load_valid = lv;
    load_value = lval;
    start      = st;
    stop       = sp;
    periodic   = per;
    e.v  = {eq, eb, et, ee, ~eb};
    e.nm = nm;
    sb.push_back(e);
  endtask

  logic [7:0] pq [12] = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; load_valid = 1'b0; load_value = '0;
    start = 1'b0; stop = 1'b0; periodic = 1'b0;

    // Reset and start rejection with q=0
    step(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, "reset");
    step(0, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, "reset_hold");
    step(1, 1, 0, 0,   1, 0, 0,  0, 0, 0, 1, "start_q0_err");
    step(1, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, "err_one_cycle");

    // One-shot from 5
    step(1, 0, 1, 5,   0, 0, 0,  5, 0, 0, 0, "load5");
    step(1, 1, 0, 0,   1, 0, 0,  5, 1, 0, 0, "start_busy");
    for (int i = 4; i >= 1; i--)
      step(1, 1, 0, 0, 0, 0, 0,  8'(i), 1, 0, 0, "oneshot_dec");
    step(1, 1, 0, 0,   0, 0, 0,  0, 0, 1, 0, "oneshot_tc");
    step(1, 1, 0, 0,   0, 0, 0,  0, 0, 0, 0, "expired_hold");

    // Periodic reload 3 with gated enable
    step(1, 0, 1, 3,   0, 0, 0,  3, 0, 0, 0, "load3_expired");
    step(1, 0, 0, 0,   1, 0, 1,  3, 1, 0, 0, "start_periodic");
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0, 0, 0, 0,  pq[i], 1, (pq[i] == 8'd3), 0, "periodic_en");
      step(1, 0, 0, 0, 0, 0, 0,  pq[i], 1, 0, 0, "periodic_gated");
    end
    step(1, 0, 0, 0,   0, 1, 0,  3, 0, 0, 0, "stop_pause");

    // Stop/resume, stop+start collision, load ignored in RUN
    step(1, 0, 1, 10,  0, 0, 0,  10, 0, 0, 0, "load10");
    step(1, 0, 0, 0,   1, 0, 0,  10, 1, 0, 0, "start10");
    for (int i = 9; i >= 6; i--)
      step(1, 1, 0, 0, 0, 0, 0,  8'(i), 1, 0, 0, "run_dec");
    step(1, 0, 1, 7,   0, 0, 0,  6, 1, 0, 0, "load_in_run_ignored");
    step(1, 0, 0, 0,   1, 1, 0,  6, 0, 0, 0, "stop_wins");
    step(1, 0, 0, 0,   1, 0, 0,  6, 1, 0, 0, "resume");
    for (int i = 5; i >= 1; i--)
      step(1, 1, 0, 0, 0, 0, 0,  8'(i), 1, 0, 0, "resume_dec");
    step(1, 1, 0, 0,   0, 0, 0,  0, 0, 1, 0, "resume_tc");
    step(1, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, "resume_single_tc");

    // Stop coinciding with the final decrement ends in IDLE
    step(1, 0, 1, 2,   1, 0, 0,  2, 1, 0, 0, "load_start_expired");
    step(1, 1, 0, 0,   0, 0, 0,  1, 1, 0, 0, "dec_to_1");
    step(1, 1, 0, 0,   0, 1, 0,  0, 0, 1, 0, "stop_on_tc");
    step(1, 0, 0, 0,   1, 0, 0,  0, 0, 0, 1, "idle_not_expired");
    step(1, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, "idle_quiet");

    // Same-cycle load+start, expiry, retrigger, start while running
    step(1, 0, 1, 2,   1, 0, 0,  2, 1, 0, 0, "load_start_idle");
    step(1, 1, 0, 0,   0, 0, 0,  1, 1, 0, 0, "ls_dec");
    step(1, 1, 0, 0,   0, 0, 0,  0, 0, 1, 0, "ls_expire");
    step(1, 0, 0, 0,   1, 0, 0,  2, 1, 0, 0, "retrigger");
    step(1, 0, 0, 0,   1, 0, 0,  2, 1, 0, 0, "start_in_run");

    // Maximum reload value wraps after 2^N-1 enabled cycles
    step(1, 0, 0, 0,   0, 1, 0,  2, 0, 0, 0, "stop_before_max");
    step(1, 0, 1, 255, 0, 0, 0,  255, 0, 0, 0, "load255");
    step(1, 0, 0, 0,   1, 0, 1,  255, 1, 0, 0, "start255");
    for (int i = 1; i <= 254; i++)
      step(1, 1, 0, 0, 0, 0, 0,  8'(255 - i), 1, 0, 0, "max_dec");
    step(1, 1, 0, 0,   0, 0, 0,  255, 1, 1, 0, "max_reload_tc");

    // Reset in the middle of a periodic run
    step(1, 0, 0, 0,   0, 1, 0,  255, 0, 0, 0, "stop_before_reset");
    step(1, 0, 1, 128, 0, 0, 0,  128, 0, 0, 0, "load128");
    step(1, 1, 0, 0,   1, 0, 1,  128, 1, 0, 0, "start128");
    step(0, 1, 0, 0,   0, 0, 1,  0, 0, 0, 0, "reset_midrun");
    step(1, 0, 0, 0,   1, 0, 0,  0, 0, 0, 1, "start_after_reset_err");
    step(1, 0, 0, 0,   0, 0, 0,  0, 0, 0, 0, "final_idle");

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
